// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave RAM with byte-enable writes, fixed waitrequest stalls
// and a synchronous preload port for loading program images.
module avalon_ram_slave #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    ACCEPT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic          req;
  logic          load;
  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] idx;
  logic [31:0]   pw;
  logic          phit;
  logic [AW-1:0] pidx;
  logic          unused_bits;

  assign req  = read | write;
  assign off  = address - BASE_ADDR;
  assign hit  = (address >= BASE_ADDR)
             && ({2'b00, off[31:2]} < DEPTH);
  assign idx  = off[AW+1:2];
  assign pw   = {26'd0, inst_addr[7:2]};
  assign phit = pw < DEPTH;
  assign pidx = pw[AW-1:0];

  assign unused_bits = ^{off[1:0], inst_addr[1:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          count_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 1) begin
            state_d = ACCEPT;
            load    = 1'b1;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        count_d = count_q - 4'd1;
        if (!req) begin
          state_d = IDLE;
        end else if (count_q == 4'd2) begin
          state_d = ACCEPT;
          load    = 1'b1;
        end
      end
      ACCEPT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a combined read+write is a write; it still clears readdata
    if (load && read) begin
      if (write)    rdata_d = '0;
      else if (hit) rdata_d = mem_q[idx];
      else          rdata_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == ACCEPT && write && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          mem_d[idx][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
    // preload is applied last so it overrides a same-word bus write
    if (inst_input && phit) begin
      mem_d[pidx] = instruction;
    end
  end

  always_comb begin
    waitrequest = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE:    waitrequest = req;
        STALL:   waitrequest = 1'b1;
        default: waitrequest = 1'b0;
      endcase
    end
  end

  assign readdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: two instances (1 and 3 wait cycles)
// against a transaction-level memory model, plus directed scenarios.
module tb_avalon_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address [2];
  logic [31:0] writedata [2];
  logic [31:0] instruction [2];
  logic [31:0] readdata [2];
  logic        read [2];
  logic        write [2];
  logic        waitrequest [2];
  logic        inst_input [2];
  logic [3:0]  byteenable [2];
  logic [7:0]  inst_addr [2];

  logic [31:0] mm [2][64];
  logic [31:0] rd_m [2];
  logic        exp_wr [2];
  bit          rd_load [2];
  bit          wr_commit [2];
  bit          chk_en = 1'b0;
  bit          rand_pl = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  avalon_ram_slave #(.DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset(reset), .address(address[0]), .write(write[0]),
    .read(read[0]), .waitrequest(waitrequest[0]),
    .writedata(writedata[0]), .byteenable(byteenable[0]),
    .readdata(readdata[0]), .inst_input(inst_input[0]),
    .inst_addr(inst_addr[0]), .instruction(instruction[0]));

  avalon_ram_slave #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .reset(reset), .address(address[1]), .write(write[1]),
    .read(read[1]), .waitrequest(waitrequest[1]),
    .writedata(writedata[1]), .byteenable(byteenable[1]),
    .readdata(readdata[1]), .inst_input(inst_input[1]),
    .inst_addr(inst_addr[1]), .instruction(instruction[1]));

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < 64;
  endfunction

  // effect of one clock edge on the reference model
  task automatic model_edge(input int i);
    logic [31:0] v;
    int          w;
    if (!reset) begin
      for (int k = 0; k < 64; k++) mm[i][k] = '0;
      rd_m[i] = '0;
    end else begin
      w = int'(address[i] >> 2);
      if (rd_load[i]) begin
        v = '0;
        if (!write[i] && in_rng(address[i])) v = mm[i][w];
        rd_m[i] = v;
      end
      if (wr_commit[i] && in_rng(address[i])) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[i][b])
            mm[i][w][8*b +: 8] = writedata[i][8*b +: 8];
      end
      if (inst_input[i]) mm[i][inst_addr[i] >> 2] = instruction[i];
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (rand_pl && $urandom_range(0, 3) == 0) begin
        inst_input[i]  = 1'b1;
        inst_addr[i]   = 8'($urandom);
        instruction[i] = $urandom;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      inst_input[i] = 1'b0;
      rd_load[i]    = 1'b0;
      wr_commit[i]  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("wait%0d", i), 32'(waitrequest[i]), 32'(exp_wr[i]));
        chk($sformatf("rdata%0d", i), readdata[i], rd_m[i]);
      end
    end
  end

  // A request issued now must stall for W cycles, then complete.
  task automatic xact(input int i, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int hi,
                      input bit pl = 1'b0, input logic [7:0] pa = '0,
                      input logic [31:0] pd = '0);
    int w;
    w  = (i == 0) ? 1 : 3;
    hi = 0;
    address[i]    = a;
    writedata[i]  = d;
    byteenable[i] = be;
    read[i]       = rd;
    write[i]      = wr;
    for (int j = 0; j <= w; j++) begin
      exp_wr[i] = (j < w);
      if (j == w - 1) rd_load[i] = rd;
      if (j == w) begin
        wr_commit[i] = wr;
        if (pl) begin
          inst_input[i]  = 1'b1;
          inst_addr[i]   = pa;
          instruction[i] = pd;
        end
      end
      #2;
      if (waitrequest[i]) hi++;
      tick();
    end
    read[i]   = 1'b0;
    write[i]  = 1'b0;
    exp_wr[i] = 1'b0;
  endtask

  task automatic preload(input int i, input logic [7:0] pa,
                         input logic [31:0] pd);
    inst_input[i]  = 1'b1;
    inst_addr[i]   = pa;
    instruction[i] = pd;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int hi;
    int i;
    int op;
    logic [31:0] a;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      address[k] = '0; writedata[k] = '0; byteenable[k] = '0;
      read[k] = 1'b0; write[k] = 1'b0; inst_input[k] = 1'b0;
      inst_addr[k] = '0; instruction[k] = '0;
      exp_wr[k] = 1'b0; rd_m[k] = '0;
      rd_load[k] = 1'b0; wr_commit[k] = 1'b0;
    end
    tick();
    tick();
    reset  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_rdata", readdata[0], 32'h0);
    chk("rst_wait", 32'(waitrequest[1]), 32'h0);

    preload(0, 8'h04, 32'h24040FF0);
    xact(0, 1, 0, 32'h04, '0, 4'h0, hi);
    chk("t1_hi", hi, 1);
    chk("t1_rd", readdata[0], 32'h24040FF0);

    xact(0, 0, 1, 32'h08, 32'hDEADBEEF, 4'b0101, hi);
    xact(0, 1, 0, 32'h08, '0, 4'h0, hi);
    chk("t2_rd", readdata[0], 32'h00AD00EF);

    xact(1, 1, 0, 32'h00, '0, 4'h0, hi);
    chk("t3_hi_a", hi, 3);
    xact(1, 1, 0, 32'h00, '0, 4'h0, hi);
    chk("t3_hi_b", hi, 3);

    xact(0, 1, 0, 32'h100, '0, 4'h0, hi);
    chk("t4_oor", readdata[0], 32'h0);
    xact(0, 0, 1, 32'h100, 32'h12345678, 4'hF, hi);
    xact(0, 1, 0, 32'h00, '0, 4'h0, hi);
    chk("t4_alias", readdata[0], 32'h0);

    xact(0, 1, 0, 32'h04, '0, 4'h0, hi);
    xact(0, 1, 1, 32'h0C, 32'hCAFEF00D, 4'hF, hi);
    chk("t5_rw", readdata[0], 32'h0);
    xact(0, 1, 0, 32'h0C, '0, 4'h0, hi);
    chk("t5_rd", readdata[0], 32'hCAFEF00D);

    xact(0, 0, 1, 32'h14, 32'hAAAAAAAA, 4'hF, hi, 1'b1, 8'h14, 32'h13579BDF);
    xact(0, 1, 0, 32'h14, '0, 4'h0, hi);
    chk("pl_wins", readdata[0], 32'h13579BDF);

    // master abandons a write mid-stall: nothing may be committed
    address[1] = 32'h18; writedata[1] = 32'h55555555;
    byteenable[1] = 4'hF; write[1] = 1'b1; exp_wr[1] = 1'b1;
    tick();
    write[1] = 1'b0;
    tick();
    exp_wr[1] = 1'b0;
    tick();
    xact(1, 1, 0, 32'h18, '0, 4'h0, hi);
    chk("drop_wr", readdata[1], 32'h0);

    address[1] = 32'h10; writedata[1] = 32'hFFFFFFFF;
    byteenable[1] = 4'hF; write[1] = 1'b1; exp_wr[1] = 1'b1;
    tick();
    reset = 1'b0;
    exp_wr[1] = 1'b0;
    #1;
    chk("t6_wait", 32'(waitrequest[1]), 32'h0);
    tick();
    reset = 1'b1;
    write[1] = 1'b0;
    tick();
    xact(1, 1, 0, 32'h10, '0, 4'h0, hi);
    chk("t6_rd", readdata[1], 32'h0);

    rand_pl = 1'b1;
    for (int n = 0; n < 300; n++) begin
      i  = n % 2;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 67) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      xact(i, op != 2, op >= 2, a, $urandom, 4'($urandom), hi);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_pl = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
